// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// ALU codes, datapath select values and the controller state encoding.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_A  = 1'b1;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12
  } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct field to ALU operation; flags functs the core does not implement.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_alu_ctrl = 3'b000;
    o_illegal  = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_ctrl = ALU_ADD;
      FN_SUB:  o_alu_ctrl = ALU_SUB;
      FN_AND:  o_alu_ctrl = ALU_AND;
      FN_OR:   o_alu_ctrl = ALU_OR;
      FN_SLT:  o_alu_ctrl = ALU_SLT;
      default: o_illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core. Define MIPS_CTRL_JAL_EN to
// support jal (opcode 0x03); otherwise that opcode is reported as illegal.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             ir_write_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic [1:0]       reg_dst_o,
  output logic [1:0]       mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_ctrl_o,
  output logic [1:0]       pc_src_o,
  output logic             illegal_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic [2:0]       w_dec_alu;
  logic             w_dec_illegal;

  mips_alu_decoder u_alu_dec (
    .i_funct    (funct_i),
    .o_alu_ctrl (w_dec_alu),
    .o_illegal  (w_dec_illegal)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    pc_en_o      = 1'b0;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = REGDST_RT;
    mem_to_reg_o = M2R_ALUOUT;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_B;
    alu_ctrl_o   = 3'b000;
    pc_src_o     = PCSRC_ALU;
    illegal_o    = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        alu_ctrl_o  = ALU_ADD;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_en_o    = 1'b1;
          w_next     = S_DECODE;
        end
      end
      // ALU precomputes the branch target while the opcode is decoded.
      S_DECODE: begin
        alu_src_b_o = SRCB_IMMSH;
        alu_ctrl_o  = ALU_ADD;
        case (opcode_i)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
`ifdef MIPS_CTRL_JAL_EN
          OP_JAL:       w_next = S_JAL;
`endif
          default: begin
            illegal_o = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = SRCA_A;
        alu_src_b_o = SRCB_IMM;
        alu_ctrl_o  = ALU_ADD;
        w_next      = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = REGDST_RT;
        mem_to_reg_o = M2R_MDR;
        w_next       = S_FETCH;
        w_retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a_o = SRCA_A;
        alu_src_b_o = SRCB_B;
        alu_ctrl_o  = w_dec_alu;
        if (w_dec_illegal) begin
          illegal_o = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_ALUWB;
        end
      end
      S_ALUWB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = REGDST_RD;
        mem_to_reg_o = M2R_ALUOUT;
        w_next       = S_FETCH;
        w_retire     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = SRCA_A;
        alu_src_b_o = SRCB_B;
        alu_ctrl_o  = ALU_SUB;
        pc_src_o    = PCSRC_ALUOUT;
        pc_en_o     = zero_i;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a_o = SRCA_A;
        alu_src_b_o = SRCB_IMM;
        alu_ctrl_o  = ALU_ADD;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = REGDST_RT;
        mem_to_reg_o = M2R_ALUOUT;
        w_next       = S_FETCH;
        w_retire     = 1'b1;
      end
      S_JUMP: begin
        pc_src_o = PCSRC_JUMP;
        pc_en_o  = 1'b1;
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
`ifdef MIPS_CTRL_JAL_EN
      // PC already holds PC+4 from fetch, so it is the link value for $31.
      S_JAL: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = REGDST_RA;
        mem_to_reg_o = M2R_PC;
        pc_src_o     = PCSRC_JUMP;
        pc_en_o      = 1'b1;
        w_next       = S_FETCH;
        w_retire     = 1'b1;
      end
`endif
      default: w_next = S_FETCH;
    endcase

    // Reset aborts the instruction in flight: no write side effects, no retire.
    if (reset_i) begin
      pc_en_o     = 1'b0;
      ir_write_o  = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
      w_retire    = 1'b0;
    end
  end

  assign state_o   = r_state;
  assign retired_o = r_retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for mips_multicycle_ctrl with hand-computed control words.
module tb_mips_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [5:0]  opcode_i;
  logic [5:0]  funct_i;
  logic        zero_i;
  logic        mem_ready_i;
  logic        pc_en_o, ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o;
  logic [1:0]  reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_src_o;
  logic        alu_src_a_o, illegal_o;
  logic [2:0]  alu_ctrl_o;
  logic [3:0]  state_o;
  logic [31:0] retired_o;
  logic [18:0] w_ctl;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef MIPS_CTRL_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .opcode_i     (opcode_i),
    .funct_i      (funct_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .pc_en_o      (pc_en_o),
    .ir_write_o   (ir_write_o),
    .iord_o       (iord_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .reg_write_o  (reg_write_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .pc_src_o     (pc_src_o),
    .illegal_o    (illegal_o),
    .state_o      (state_o),
    .retired_o    (retired_o)
  );

  always #5 clk_i = ~clk_i;

  assign w_ctl = {pc_en_o, ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o,
                  reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_ctrl_o,
                  pc_src_o, illegal_o};

  function automatic logic [18:0] cw(bit pe, bit irw, bit iord, bit mr, bit mw, bit rw,
                                     logic [1:0] rd, logic [1:0] m2r, bit sa,
                                     logic [1:0] sb, logic [2:0] alu, logic [1:0] ps,
                                     bit ill);
    return {pe, irw, iord, mr, mw, rw, rd, m2r, sa, sb, alu, ps, ill};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drives one cycle's inputs, checks state/control mid-cycle, then advances a clock.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input logic [3:0] est,
                     input logic [18:0] ectl);
    opcode_i    = op;
    funct_i     = fn;
    zero_i      = z;
    mem_ready_i = rdy;
    #1;
    check({tag, ".st"}, 64'(state_o), 64'(est));
    check({tag, ".ctl"}, 64'(w_ctl), 64'(ectl));
    @(posedge clk_i);
    #1;
  endtask

  logic [18:0] C_FETCH, C_FSTALL, C_FRST, C_DEC, C_DECILL, C_MADR, C_MRD, C_MRDRST;
  logic [18:0] C_MWB, C_MWR, C_EXSLT, C_EXILL, C_ALUWB, C_BRT, C_BRNT, C_AEX, C_AWB;
  logic [18:0] C_JMP, C_JAL;

  initial begin
    //             pe irw iord mr mw rw rd     m2r    sa sb     alu     ps     ill
    C_FETCH  = cw(1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b01, 3'b010, 2'b00, 0);
    C_FSTALL = cw(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b01, 3'b010, 2'b00, 0);
    C_FRST   = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 3'b010, 2'b00, 0);
    C_DEC    = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 3'b010, 2'b00, 0);
    C_DECILL = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 3'b010, 2'b00, 1);
    C_MADR   = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b010, 2'b00, 0);
    C_MRD    = cw(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 2'b00, 0);
    C_MRDRST = cw(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 2'b00, 0);
    C_MWB    = cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 3'b000, 2'b00, 0);
    C_MWR    = cw(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 2'b00, 0);
    C_EXSLT  = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b111, 2'b00, 0);
    C_EXILL  = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b000, 2'b00, 1);
    C_ALUWB  = cw(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 3'b000, 2'b00, 0);
    C_BRT    = cw(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b110, 2'b01, 0);
    C_BRNT   = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b110, 2'b01, 0);
    C_AEX    = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b010, 2'b00, 0);
    C_AWB    = cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3'b000, 2'b00, 0);
    C_JMP    = cw(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 2'b10, 0);
    C_JAL    = cw(1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 3'b000, 2'b10, 0);

    reset_i     = 1'b1;
    opcode_i    = 6'h00;
    funct_i     = 6'h00;
    zero_i      = 1'b0;
    mem_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst.st", 64'(state_o), 64'd0);
    check("rst.ret", 64'(retired_o), 64'd0);
    check("rst.ctl", 64'(w_ctl), 64'(C_FRST));
    reset_i = 1'b0;

    // lw, no stalls
    run("lw.f",  6'h23, 6'h00, 0, 1, 4'd0, C_FETCH);
    run("lw.d",  6'h23, 6'h00, 0, 1, 4'd1, C_DEC);
    run("lw.a",  6'h23, 6'h00, 0, 1, 4'd2, C_MADR);
    run("lw.r",  6'h23, 6'h00, 0, 1, 4'd3, C_MRD);
    run("lw.wb", 6'h23, 6'h00, 0, 1, 4'd4, C_MWB);
    check("lw.ret", 64'(retired_o), 64'd1);

    // sw with three stalled cycles in MEMWR
    run("sw.f",  6'h2B, 6'h00, 0, 1, 4'd0, C_FETCH);
    run("sw.d",  6'h2B, 6'h00, 0, 1, 4'd1, C_DEC);
    run("sw.a",  6'h2B, 6'h00, 0, 1, 4'd2, C_MADR);
    for (int i = 0; i < 3; i++) begin
      run("sw.stall", 6'h2B, 6'h00, 0, 0, 4'd5, C_MWR);
      check("sw.stall.ret", 64'(retired_o), 64'd1);
    end
    run("sw.w",  6'h2B, 6'h00, 0, 1, 4'd5, C_MWR);
    check("sw.ret", 64'(retired_o), 64'd2);

    // beq taken, then not taken
    run("beqT.f", 6'h04, 6'h00, 1, 1, 4'd0, C_FETCH);
    run("beqT.d", 6'h04, 6'h00, 1, 1, 4'd1, C_DEC);
    run("beqT.b", 6'h04, 6'h00, 1, 1, 4'd8, C_BRT);
    check("beqT.ret", 64'(retired_o), 64'd3);
    run("beqN.f", 6'h04, 6'h00, 0, 1, 4'd0, C_FETCH);
    run("beqN.d", 6'h04, 6'h00, 0, 1, 4'd1, C_DEC);
    run("beqN.b", 6'h04, 6'h00, 0, 1, 4'd8, C_BRNT);
    check("beqN.ret", 64'(retired_o), 64'd4);

    // R-type slt, then an unsupported funct (nor)
    run("slt.f",  6'h00, 6'h2A, 0, 1, 4'd0, C_FETCH);
    run("slt.d",  6'h00, 6'h2A, 0, 1, 4'd1, C_DEC);
    run("slt.x",  6'h00, 6'h2A, 0, 1, 4'd6, C_EXSLT);
    run("slt.wb", 6'h00, 6'h2A, 0, 1, 4'd7, C_ALUWB);
    check("slt.ret", 64'(retired_o), 64'd5);
    run("nor.f",  6'h00, 6'h27, 0, 1, 4'd0, C_FETCH);
    run("nor.d",  6'h00, 6'h27, 0, 1, 4'd1, C_DEC);
    run("nor.x",  6'h00, 6'h27, 0, 1, 4'd6, C_EXILL);
    check("nor.st", 64'(state_o), 64'd0);
    check("nor.ret", 64'(retired_o), 64'd5);

    // addi and j
    run("addi.f", 6'h08, 6'h00, 0, 1, 4'd0, C_FETCH);
    run("addi.d", 6'h08, 6'h00, 0, 1, 4'd1, C_DEC);
    run("addi.x", 6'h08, 6'h00, 0, 1, 4'd9, C_AEX);
    run("addi.w", 6'h08, 6'h00, 0, 1, 4'd10, C_AWB);
    check("addi.ret", 64'(retired_o), 64'd6);
    run("j.f", 6'h02, 6'h00, 0, 1, 4'd0, C_FETCH);
    run("j.d", 6'h02, 6'h00, 0, 1, 4'd1, C_DEC);
    run("j.j", 6'h02, 6'h00, 0, 1, 4'd11, C_JMP);
    check("j.ret", 64'(retired_o), 64'd7);

    // jal: supported only when the feature is built in
    run("jal.f", 6'h03, 6'h00, 0, 1, 4'd0, C_FETCH);
    if (JAL_EN) begin
      run("jal.d", 6'h03, 6'h00, 0, 1, 4'd1, C_DEC);
      run("jal.j", 6'h03, 6'h00, 0, 1, 4'd12, C_JAL);
      check("jal.ret", 64'(retired_o), 64'd8);
    end else begin
      run("jal.d", 6'h03, 6'h00, 0, 1, 4'd1, C_DECILL);
      check("jal.st", 64'(state_o), 64'd0);
      check("jal.ret", 64'(retired_o), 64'd7);
    end

    // undefined opcode, preceded by a stalled fetch
    run("und.fs", 6'h3F, 6'h00, 0, 0, 4'd0, C_FSTALL);
    run("und.fs", 6'h3F, 6'h00, 0, 0, 4'd0, C_FSTALL);
    run("und.f",  6'h3F, 6'h00, 0, 1, 4'd0, C_FETCH);
    run("und.d",  6'h3F, 6'h00, 0, 1, 4'd1, C_DECILL);
    check("und.st", 64'(state_o), 64'd0);
    check("und.ret", 64'(retired_o), 64'd7 + 64'(JAL_EN));

    // reset while a lw is stalled in MEMRD
    run("rlw.f", 6'h23, 6'h00, 0, 1, 4'd0, C_FETCH);
    run("rlw.d", 6'h23, 6'h00, 0, 1, 4'd1, C_DEC);
    run("rlw.a", 6'h23, 6'h00, 0, 1, 4'd2, C_MADR);
    run("rlw.s", 6'h23, 6'h00, 0, 0, 4'd3, C_MRD);
    reset_i = 1'b1;
    run("rlw.rst", 6'h23, 6'h00, 0, 1, 4'd3, C_MRDRST);
    check("rlw.st", 64'(state_o), 64'd0);
    check("rlw.ret", 64'(retired_o), 64'd0);
    reset_i = 1'b0;
    run("post.f", 6'h23, 6'h00, 0, 1, 4'd0, C_FETCH);
    check("post.st", 64'(state_o), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
